// File: rtl/key_pkg.sv
// Shared timing defaults for the push-button conditioner.
// The defaults assume a 100 MHz system clock: a 20 ms debounce window
// and a 1 s long-press threshold. Counter widths are derived from these
// defaults so that each counter can hold its terminal value.
package key_pkg;

  localparam int CLK_HZ             = 100_000_000;
  localparam int STABLE_CYCLES_20MS = CLK_HZ / 50;
  localparam int LONG_CYCLES_1S     = CLK_HZ;

  // Smallest width whose range strictly exceeds the given cycle count.
  function automatic int width_for(input int cycles);
    return $clog2(cycles + 1);
  endfunction

  localparam int CNT_W  = width_for(STABLE_CYCLES_20MS);
  localparam int LONG_W = width_for(LONG_CYCLES_1S);

  // Raw input level of an idle (unpressed) key for a given polarity.
  function automatic logic idle_raw_level(input int active_low);
    return (active_low != 0);
  endfunction

endpackage

// File: rtl/key_debounce_chan.sv
// One key channel: synchroniser, consecutive-stable debounce counter,
// normalised level register, press/release pulses and a one-shot
// long-press detector that re-arms on release.
module key_debounce_chan #(
  parameter int ACTIVE_LOW    = 1,
  parameter int SYNC_STAGES   = 2,
  parameter int STABLE_CYCLES = key_pkg::STABLE_CYCLES_20MS,
  parameter int CNT_W         = key_pkg::CNT_W,
  parameter int LONG_CYCLES   = key_pkg::LONG_CYCLES_1S,
  parameter int LONG_W        = key_pkg::LONG_W
) (
  input  logic clk,
  input  logic rst,
  input  logic key_raw,
  output logic key_level,
  output logic press_pulse,
  output logic release_pulse,
  output logic long_pulse
);

  import key_pkg::idle_raw_level;

  localparam logic              IDLE_RAW    = idle_raw_level(ACTIVE_LOW);
  localparam logic [CNT_W-1:0]  STABLE_LAST = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [LONG_W-1:0] LONG_LAST   = LONG_W'(LONG_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [CNT_W-1:0]       db_cnt;
  logic [LONG_W-1:0]      hold_cnt;
  logic                   armed;

  logic pressed;
  logic differs;
  logic accept;
  logic release_accept;

  // Bring the asynchronous key into the clock domain; idle level on reset
  // so that a held key after reset is seen as a fresh transition.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_q <= {SYNC_STAGES{IDLE_RAW}};
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], key_raw};
    end
  end

  // Polarity-normalised key and the acceptance condition of the debouncer.
  always_comb begin
    pressed        = sync_q[SYNC_STAGES-1] ^ IDLE_RAW;
    differs        = (pressed != key_level);
    accept         = differs && (db_cnt == STABLE_LAST);
    release_accept = accept && !pressed;
  end

  // Count consecutive disagreeing cycles; any agreement restarts the count,
  // and the new level is taken only after a full unbroken window.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      db_cnt        <= '0;
      key_level     <= 1'b0;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
    end else begin
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      if (!differs) begin
        db_cnt <= '0;
      end else if (accept) begin
        db_cnt        <= '0;
        key_level     <= pressed;
        press_pulse   <= pressed;
        release_pulse <= !pressed;
      end else begin
        db_cnt <= db_cnt + CNT_W'(1);
      end
    end
  end

  // Time a held press once; the counter parks at its terminal value until
  // the key is released, which clears it and re-arms the detector. A long
  // pulse is withheld on the cycle a release is being accepted so the two
  // pulses never coincide.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hold_cnt   <= '0;
      armed      <= 1'b1;
      long_pulse <= 1'b0;
    end else begin
      long_pulse <= 1'b0;
      if (!key_level) begin
        hold_cnt <= '0;
        armed    <= 1'b1;
      end else if (armed) begin
        if (hold_cnt == LONG_LAST) begin
          if (!release_accept) begin
            long_pulse <= 1'b1;
            armed      <= 1'b0;
          end
        end else begin
          hold_cnt <= hold_cnt + LONG_W'(1);
        end
      end
    end
  end

endmodule

// File: rtl/key_debouncer_multi.sv
// N independent push-button conditioners feeding the debug/step-control
// logic. Each channel has its own synchroniser and counters so that
// simultaneous activity on several keys cannot interact.
module key_debouncer_multi #(
  parameter int N             = 4,
  parameter int ACTIVE_LOW    = 1,
  parameter int SYNC_STAGES   = 2,
  parameter int STABLE_CYCLES = key_pkg::STABLE_CYCLES_20MS,
  parameter int CNT_W         = key_pkg::CNT_W,
  parameter int LONG_CYCLES   = key_pkg::LONG_CYCLES_1S,
  parameter int LONG_W        = key_pkg::LONG_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] key_raw,
  output logic [N-1:0] key_level,
  output logic [N-1:0] press_pulse,
  output logic [N-1:0] release_pulse,
  output logic [N-1:0] long_pulse
);

  // Reject parameter sets whose counters could not reach their terminal values.
  if (SYNC_STAGES < 2) begin : g_bad_sync
    $error("key_debouncer_multi: SYNC_STAGES must be >= 2");
  end
  if (STABLE_CYCLES < 2) begin : g_bad_stable
    $error("key_debouncer_multi: STABLE_CYCLES must be >= 2");
  end
  if (LONG_CYCLES < 2) begin : g_bad_long
    $error("key_debouncer_multi: LONG_CYCLES must be >= 2");
  end
  if ((64'd1 << CNT_W) <= 64'(STABLE_CYCLES)) begin : g_bad_cnt_w
    $error("key_debouncer_multi: CNT_W too small for STABLE_CYCLES");
  end
  if ((64'd1 << LONG_W) <= 64'(LONG_CYCLES)) begin : g_bad_long_w
    $error("key_debouncer_multi: LONG_W too small for LONG_CYCLES");
  end

  // One self-contained conditioner per key.
  for (genvar i = 0; i < N; i++) begin : g_chan
    key_debounce_chan #(
      .ACTIVE_LOW   (ACTIVE_LOW),
      .SYNC_STAGES  (SYNC_STAGES),
      .STABLE_CYCLES(STABLE_CYCLES),
      .CNT_W        (CNT_W),
      .LONG_CYCLES  (LONG_CYCLES),
      .LONG_W       (LONG_W)
    ) u_chan (
      .clk          (clk),
      .rst          (rst),
      .key_raw      (key_raw[i]),
      .key_level    (key_level[i]),
      .press_pulse  (press_pulse[i]),
      .release_pulse(release_pulse[i]),
      .long_pulse   (long_pulse[i])
    );
  end

endmodule

// File: tb/tb_key_debouncer_multi.sv
// Scoreboard bench for key_debouncer_multi with short timing constants.
// Stimulus pushes the expected pulse events (edge number and pulse
// vectors, hand-derived from the debounce timing) into a queue; a monitor
// on the falling edge pops and compares whenever any pulse is presented,
// and flags expected events whose edge has passed without a pulse.
module tb_key_debouncer_multi;

  localparam int N             = 2;
  localparam int ACTIVE_LOW    = 1;
  localparam int SYNC_STAGES   = 2;
  localparam int STABLE_CYCLES = 4;
  localparam int CNT_W         = 3;
  localparam int LONG_CYCLES   = 10;
  localparam int LONG_W        = 4;

  // Edges from the driving edge to the pulse edge.
  localparam int PRESS_LAT = SYNC_STAGES + STABLE_CYCLES;

  localparam int K_PRESS   = 0;
  localparam int K_RELEASE = 1;
  localparam int K_LONG    = 2;

  logic         clk = 1'b0;
  logic         rst;
  logic [N-1:0] key_raw;
  logic [N-1:0] key_level;
  logic [N-1:0] press_pulse;
  logic [N-1:0] release_pulse;
  logic [N-1:0] long_pulse;

  typedef struct {
    int           edge_no;
    logic [N-1:0] press;
    logic [N-1:0] rel;
    logic [N-1:0] lng;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_rec;
  int   errors   = 0;
  int   checks   = 0;
  int   edge_cnt = 0;
  int   t0;

  always #5 clk = ~clk;

  key_debouncer_multi #(
    .N            (N),
    .ACTIVE_LOW   (ACTIVE_LOW),
    .SYNC_STAGES  (SYNC_STAGES),
    .STABLE_CYCLES(STABLE_CYCLES),
    .CNT_W        (CNT_W),
    .LONG_CYCLES  (LONG_CYCLES),
    .LONG_W       (LONG_W)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .key_raw      (key_raw),
    .key_level    (key_level),
    .press_pulse  (press_pulse),
    .release_pulse(release_pulse),
    .long_pulse   (long_pulse)
  );

  // Number of rising edges so far; the event at edge k is visible after it.
  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  // Insert an expected pulse, merging with any event already due on that edge.
  function automatic void push_exp(input int edge_no, input int ch, input int kind);
    exp_t r;
    int   idx;
    idx = exp_q.size();
    for (int i = 0; i < exp_q.size(); i++) begin
      if (exp_q[i].edge_no == edge_no) begin
        r = exp_q[i];
        if (kind == K_PRESS)   r.press[ch] = 1'b1;
        if (kind == K_RELEASE) r.rel[ch]   = 1'b1;
        if (kind == K_LONG)    r.lng[ch]   = 1'b1;
        exp_q[i] = r;
        return;
      end
    end
    for (int i = 0; i < exp_q.size(); i++) begin
      if (exp_q[i].edge_no > edge_no) begin
        idx = i;
        break;
      end
    end
    r.edge_no = edge_no;
    r.press   = '0;
    r.rel     = '0;
    r.lng     = '0;
    if (kind == K_PRESS)   r.press[ch] = 1'b1;
    if (kind == K_RELEASE) r.rel[ch]   = 1'b1;
    if (kind == K_LONG)    r.lng[ch]   = 1'b1;
    exp_q.insert(idx, r);
  endfunction

  task automatic check_output(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic apply_stimulus(input logic [N-1:0] raw);
    key_raw = raw;
  endtask

  // Monitor: compare every presented pulse against the scoreboard head.
  always @(negedge clk) begin
    if ((press_pulse | release_pulse | long_pulse) != '0) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("[TB] FAIL unexpected_pulse: edge=%0d press=%b release=%b long=%b, expected no pulse",
                 edge_cnt, press_pulse, release_pulse, long_pulse);
      end else begin
        mon_rec = exp_q.pop_front();
        if (edge_cnt != mon_rec.edge_no || press_pulse !== mon_rec.press ||
            release_pulse !== mon_rec.rel || long_pulse !== mon_rec.lng) begin
          errors++;
          $display("[TB] FAIL pulse_event: got edge=%0d press=%b release=%b long=%b, expected edge=%0d press=%b release=%b long=%b",
                   edge_cnt, press_pulse, release_pulse, long_pulse,
                   mon_rec.edge_no, mon_rec.press, mon_rec.rel, mon_rec.lng);
        end
      end
    end else if (exp_q.size() > 0 && exp_q[0].edge_no <= edge_cnt) begin
      mon_rec = exp_q.pop_front();
      checks++;
      errors++;
      $display("[TB] FAIL missing_pulse: got none at edge=%0d, expected press=%b release=%b long=%b at edge=%0d",
               edge_cnt, mon_rec.press, mon_rec.rel, mon_rec.lng, mon_rec.edge_no);
    end
  end

  initial begin
    rst = 1'b0;
    apply_stimulus(2'b11);

    // Reset state while rst is held low.
    step(3);
    check_output("reset_level", 32'(key_level), 32'h0);
    check_output("reset_pulses", 32'({press_pulse, release_pulse, long_pulse}), 32'h0);
    rst = 1'b1;

    // Idle keys: nothing should happen for 20 cycles.
    step(20);
    check_output("idle_level", 32'(key_level), 32'h0);

    // Channel 0 press: press after 6 edges, long press 10 edges later.
    t0 = edge_cnt;
    apply_stimulus(2'b10);
    push_exp(t0 + PRESS_LAT, 0, K_PRESS);
    push_exp(t0 + PRESS_LAT + LONG_CYCLES, 0, K_LONG);
    step(PRESS_LAT);
    check_output("single_press_level", 32'(key_level), 32'h1);
    step(19);
    t0 = edge_cnt;
    apply_stimulus(2'b11);
    push_exp(t0 + PRESS_LAT, 0, K_RELEASE);
    step(12);
    check_output("single_release_level", 32'(key_level), 32'h0);

    // Bounce bursts: 3 low, 1 high, five times; never accepted.
    for (int i = 0; i < 5; i++) begin
      apply_stimulus(2'b10);
      step(3);
      apply_stimulus(2'b11);
      step(1);
    end
    step(10);
    check_output("bounce_level", 32'(key_level), 32'h0);

    // Both keys together; channel 1 released before it can reach long press.
    t0 = edge_cnt;
    apply_stimulus(2'b00);
    push_exp(t0 + PRESS_LAT, 0, K_PRESS);
    push_exp(t0 + PRESS_LAT, 1, K_PRESS);
    push_exp(t0 + PRESS_LAT + LONG_CYCLES, 0, K_LONG);
    step(8);
    check_output("dual_press_level", 32'(key_level), 32'h3);
    apply_stimulus(2'b10);
    push_exp(t0 + 8 + PRESS_LAT, 1, K_RELEASE);

    // Channel 0 held 40 cycles in total: one long pulse only, then re-press.
    step(32);
    apply_stimulus(2'b11);
    push_exp(t0 + 40 + PRESS_LAT, 0, K_RELEASE);
    step(10);
    t0 = edge_cnt;
    apply_stimulus(2'b10);
    push_exp(t0 + PRESS_LAT, 0, K_PRESS);
    push_exp(t0 + PRESS_LAT + LONG_CYCLES, 0, K_LONG);
    step(20);
    apply_stimulus(2'b11);
    push_exp(t0 + 20 + PRESS_LAT, 0, K_RELEASE);
    step(10);
    check_output("repress_level", 32'(key_level), 32'h0);

    // Reset while the channel 0 debounce counter is at 2, key kept pressed.
    apply_stimulus(2'b10);
    step(4);
    rst = 1'b0;
    #1;
    check_output("midreset_level", 32'(key_level), 32'h0);
    check_output("midreset_pulses", 32'({press_pulse, release_pulse, long_pulse}), 32'h0);
    step(3);
    t0 = edge_cnt;
    rst = 1'b1;
    push_exp(t0 + PRESS_LAT, 0, K_PRESS);
    push_exp(t0 + PRESS_LAT + LONG_CYCLES, 0, K_LONG);
    step(20);
    apply_stimulus(2'b11);
    push_exp(t0 + 20 + PRESS_LAT, 0, K_RELEASE);
    step(12);
    check_output("postreset_level", 32'(key_level), 32'h0);

    check_output("queue_drained", 32'(exp_q.size()), 32'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
